pipeline_hazard_unit: RTL

Parametrised hazard, forwarding and flush controller for the in-order RISC-V pipeline. It tracks destination tags for DEPTH post-decode stages (EX=1 … WB=DEPTH) in an internal shift register. Each cycle it produces the forwarding selects for the decode-stage operand muxes, a load-use stall for PC/IR1, and a squash on a taken branch/jump. It also maintains saturating stall/flush performance counters.

---
 rtl/pipeline_hazard_unit.sv | 123 ++++++++++++
 1 files changed

// File: rtl/pipeline_hazard_unit.sv
// Hazard, forwarding and flush control for the in-order pipeline: tracks destination
// tags of the post-decode stages and derives forwarding selects, load-use stall and squash.
module pipeline_hazard_unit #(
    parameter int DEPTH     = 3,
    parameter int REGW      = 5,
    parameter int LOADSTAGE = 2,
    parameter int CNTW      = 32,
    parameter int SELW      = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            id_valid,
    input  logic [REGW-1:0] id_rs1,
    input  logic            id_rs1_used,
    input  logic [REGW-1:0] id_rs2,
    input  logic            id_rs2_used,
    input  logic [REGW-1:0] id_rd,
    input  logic            id_regwrite,
    input  logic            id_isload,
    input  logic            ex_redirect,
    output logic            issue,
    output logic            stall,
    output logic            flush,
    output logic [SELW-1:0] fwd1_sel,
    output logic [SELW-1:0] fwd2_sel,
    output logic [DEPTH-1:0] stage_valid,
    output logic [CNTW-1:0] stall_count,
    output logic [CNTW-1:0] flush_count
);

    logic [DEPTH-1:0] r_valid;
    logic [DEPTH-1:0] r_regwrite;
    logic [DEPTH-1:0] r_isload;
    logic [REGW-1:0]  r_rd [DEPTH];
    logic [CNTW-1:0]  r_stallCount;
    logic [CNTW-1:0]  r_flushCount;

    logic [DEPTH-1:0] w_match1;
    logic [DEPTH-1:0] w_match2;
    logic [SELW-1:0]  w_sel1;
    logic [SELW-1:0]  w_sel2;
    logic             w_hazard1;
    logic             w_hazard2;
    logic             w_stall;
    logic             w_flush;
    logic             w_issue;

    // Scan from oldest to youngest so the youngest matching producer overwrites the select.
    always_comb begin
        w_match1  = '0;
        w_match2  = '0;
        w_sel1    = '0;
        w_sel2    = '0;
        w_hazard1 = 1'b0;
        w_hazard2 = 1'b0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            w_match1[k] = id_valid && id_rs1_used && (id_rs1 != '0) &&
                          r_valid[k] && r_regwrite[k] && (r_rd[k] == id_rs1);
            w_match2[k] = id_valid && id_rs2_used && (id_rs2 != '0) &&
                          r_valid[k] && r_regwrite[k] && (r_rd[k] == id_rs2);
            if (w_match1[k]) begin
                w_sel1    = SELW'(k + 1);
                w_hazard1 = r_isload[k] && ((k + 1) < LOADSTAGE);
            end
            if (w_match2[k]) begin
                w_sel2    = SELW'(k + 1);
                w_hazard2 = r_isload[k] && ((k + 1) < LOADSTAGE);
            end
        end
    end

    assign w_flush = !reset && ex_redirect;
    assign w_stall = !reset && (w_hazard1 || w_hazard2) && !ex_redirect;
    assign w_issue = !reset && id_valid && !w_stall && !w_flush;

    assign issue       = w_issue;
    assign stall       = w_stall;
    assign flush       = w_flush;
    assign fwd1_sel    = reset ? '0 : w_sel1;
    assign fwd2_sel    = reset ? '0 : w_sel2;
    assign stage_valid = r_valid;
    assign stall_count = r_stallCount;
    assign flush_count = r_flushCount;

    // Stage 1 takes the decode tag only on issue; stalls and squashes inject a bubble.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid    <= '0;
            r_regwrite <= '0;
            r_isload   <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                r_rd[k] <= '0;
            end
        end else begin
            for (int k = DEPTH - 1; k >= 1; k--) begin
                r_valid[k]    <= r_valid[k-1];
                r_regwrite[k] <= r_regwrite[k-1];
                r_isload[k]   <= r_isload[k-1];
                r_rd[k]       <= r_rd[k-1];
            end
            r_valid[0]    <= w_issue;
            r_regwrite[0] <= w_issue && id_regwrite;
            r_isload[0]   <= w_issue && id_isload;
            r_rd[0]       <= w_issue ? id_rd : '0;
        end
    end

    // Performance counters stick at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stallCount <= '0;
            r_flushCount <= '0;
        end else begin
            if (w_stall && !(&r_stallCount)) begin
                r_stallCount <= r_stallCount + 1'b1;
            end
            if (w_flush && !(&r_flushCount)) begin
                r_flushCount <= r_flushCount + 1'b1;
            end
        end
    end

endmodule
